// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - T0..T4 phase and strobe sequencer for the 8-bit RISC core
//
// Purpose: steps the core through the phases P0..P4. T3 is stretched for
// memory-class ops until MemReady, with a bounded timeout. HALT and timeout
// park the core until Reset.
// Ports:
//   clk, Reset                 clock (rising edge), async active-high reset
//   Opcode[4:0]                instruction opcode, latched at the end of P1
//   Zflag, Cflag               ALU flags, used by JZ/JC in T4
//   MemReady                   memory/port completion, sampled in T3
//   T0..T4                     one-hot phase indicators
//   InstRead .. PCupdate       per-phase enables
//   Halted, BusError           sticky stop indicators
//   RetiredCnt[CNT_W-1:0]      retired instruction count (wraps)
module phase_sequencer #(
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [4:0]       Opcode,
    input  logic             Zflag,
    input  logic             Cflag,
    input  logic             MemReady,
    output logic             T0,
    output logic             T1,
    output logic             T2,
    output logic             T3,
    output logic             T4,
    output logic             InstRead,
    output logic             RegFileRead,
    output logic             ALUSave,
    output logic             ZflagSave,
    output logic             CflagSave,
    output logic             SRAMRead,
    output logic             SRAMWrite,
    output logic             StackRead,
    output logic             StackWrite,
    output logic             INportRead,
    output logic             OUTportWrite,
    output logic             RegFileWrite,
    output logic             PCenable,
    output logic             PCupdate,
    output logic             Halted,
    output logic             BusError,
    output logic [CNT_W-1:0] RetiredCnt
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    localparam logic [4:0] OP_LOAD  = 5'h10;
    localparam logic [4:0] OP_STORE = 5'h11;
    localparam logic [4:0] OP_PUSH  = 5'h12;
    localparam logic [4:0] OP_POP   = 5'h13;
    localparam logic [4:0] OP_IN    = 5'h14;
    localparam logic [4:0] OP_OUT   = 5'h15;
    localparam logic [4:0] OP_JMP   = 5'h16;
    localparam logic [4:0] OP_JZ    = 5'h17;
    localparam logic [4:0] OP_JC    = 5'h18;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE, S_P0, S_P1, S_P2, S_P3, S_P4, S_HALT
    } state_t;

    state_t     state;
    logic [4:0] op_q;
    logic [7:0] wait_cnt;

    logic is_alu;
    logic is_mem;
    logic jump_taken;

    assign is_alu = (op_q >= 5'h01) && (op_q <= 5'h0F);
    assign is_mem = (op_q >= OP_LOAD) && (op_q <= OP_OUT);
    assign jump_taken = (op_q == OP_JMP) ||
                        ((op_q == OP_JZ) && Zflag) ||
                        ((op_q == OP_JC) && Cflag);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            op_q       <= 5'h00;
            wait_cnt   <= 8'd0;
            Halted     <= 1'b0;
            BusError   <= 1'b0;
            RetiredCnt <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_P0;
                S_P0:   state <= S_P1;
                S_P1: begin
                    op_q  <= Opcode;
                    state <= S_P2;
                end
                S_P2: begin
                    wait_cnt <= 8'd0;
                    state    <= S_P3;
                end
                S_P3: begin
                    if (!is_mem || MemReady) begin
                        state <= S_P4;
                    end else if (wait_cnt == WAIT_LIM) begin
                        // Timeout: the instruction is abandoned, not retired.
                        BusError <= 1'b1;
                        Halted   <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_P4: begin
                    RetiredCnt <= RetiredCnt + 1'b1;
                    if (op_q == OP_HALT) begin
                        Halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_P0;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Everything below decodes from registered state and latched opcode, so
    // an async reset clears every strobe immediately. Only the T4 jump
    // decision looks at the live flags.
    always_comb begin
        T0           = (state == S_P0);
        T1           = (state == S_P1);
        T2           = (state == S_P2);
        T3           = (state == S_P3);
        T4           = (state == S_P4);
        InstRead     = T0;
        RegFileRead  = T1;
        ALUSave      = T2 && is_alu;
        ZflagSave    = T2 && is_alu;
        CflagSave    = T2 && is_alu;
        SRAMRead     = T3 && (op_q == OP_LOAD);
        SRAMWrite    = T3 && (op_q == OP_STORE);
        StackWrite   = T3 && (op_q == OP_PUSH);
        StackRead    = T3 && (op_q == OP_POP);
        INportRead   = T3 && (op_q == OP_IN);
        OUTportWrite = T3 && (op_q == OP_OUT);
        RegFileWrite = T4 && (is_alu || (op_q == OP_LOAD) ||
                              (op_q == OP_POP) || (op_q == OP_IN));
        PCupdate     = T4 && jump_taken;
        PCenable     = T4 && !jump_taken && (op_q != OP_HALT);
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - randomized self-checking bench for phase_sequencer
module tb_phase_sequencer;

    localparam int WMAX = 4;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic [4:0]    Opcode = 5'h00;
    logic          Zflag = 1'b0;
    logic          Cflag = 1'b0;
    logic          MemReady = 1'b0;
    logic          T0, T1, T2, T3, T4;
    logic          InstRead, RegFileRead, ALUSave, ZflagSave, CflagSave;
    logic          SRAMRead, SRAMWrite, StackRead, StackWrite, INportRead, OUTportWrite;
    logic          RegFileWrite, PCenable, PCupdate, Halted, BusError;
    logic [CW-1:0] RetiredCnt;

    int vectors = 0;
    int miscompares = 0;

    int exp_ret = 0;
    logic exp_halted = 1'b0;
    logic exp_buserr = 1'b0;

    phase_sequencer #(.WAIT_MAX(WMAX), .CNT_W(CW)) dut (
        .clk(clk), .Reset(Reset), .Opcode(Opcode), .Zflag(Zflag), .Cflag(Cflag),
        .MemReady(MemReady), .T0(T0), .T1(T1), .T2(T2), .T3(T3), .T4(T4),
        .InstRead(InstRead), .RegFileRead(RegFileRead), .ALUSave(ALUSave),
        .ZflagSave(ZflagSave), .CflagSave(CflagSave), .SRAMRead(SRAMRead),
        .SRAMWrite(SRAMWrite), .StackRead(StackRead), .StackWrite(StackWrite),
        .INportRead(INportRead), .OUTportWrite(OUTportWrite),
        .RegFileWrite(RegFileWrite), .PCenable(PCenable), .PCupdate(PCupdate),
        .Halted(Halted), .BusError(BusError), .RetiredCnt(RetiredCnt)
    );

    always #5 clk = ~clk;

    logic [18:0] got;
    assign got = {T0, T1, T2, T3, T4, InstRead, RegFileRead, ALUSave, ZflagSave,
                  CflagSave, SRAMRead, SRAMWrite, StackRead, StackWrite, INportRead,
                  OUTportWrite, RegFileWrite, PCenable, PCupdate};

    // Output table from the instruction-class rules; phase 5 means "no phase".
    function automatic logic [18:0] exp_vec(input int ph, input logic [4:0] op,
                                            input logic z, input logic c);
        logic alu, taken;
        logic [4:0] t;
        alu   = (op >= 5'h01) && (op <= 5'h0F);
        taken = (op == 5'h16) || (op == 5'h17 && z) || (op == 5'h18 && c);
        t = 5'b0;
        if (ph < 5) t[4-ph] = 1'b1;
        return {t, ph == 0, ph == 1, {3{ph == 2 && alu}},
                ph == 3 && op == 5'h10, ph == 3 && op == 5'h11,
                ph == 3 && op == 5'h13, ph == 3 && op == 5'h12,
                ph == 3 && op == 5'h14, ph == 3 && op == 5'h15,
                ph == 4 && (alu || op == 5'h10 || op == 5'h13 || op == 5'h14),
                ph == 4 && op != 5'h1F && !taken,
                ph == 4 && taken};
    endfunction

    task automatic check_status(input string name, input logic [18:0] ev);
        vectors++;
        if (got !== ev) begin
            miscompares++;
            $display("FAIL %s outputs: got %b required %b", name, got, ev);
        end
        vectors++;
        if (RetiredCnt !== CW'(exp_ret) || Halted !== exp_halted || BusError !== exp_buserr) begin
            miscompares++;
            $display("FAIL %s status: got cnt=%0d halt=%b berr=%b required cnt=%0d halt=%b berr=%b",
                     name, RetiredCnt, Halted, BusError, CW'(exp_ret), exp_halted, exp_buserr);
        end
    endtask

    // Runs one instruction starting in its P0 cycle. nwait > WMAX on a
    // memory op means MemReady never arrives. abort_at >= 0 fires an async
    // reset mid-cycle in that cycle.
    task automatic do_instr(input string name, input logic [4:0] op, input int nwait,
                            input logic z, input logic c, input int abort_at);
        logic mem, tmo;
        int p3len, len, ph;
        mem   = (op >= 5'h10) && (op <= 5'h15);
        tmo   = mem && (nwait > WMAX);
        p3len = tmo ? WMAX + 1 : (mem ? nwait + 1 : 1);
        len   = 3 + p3len + (tmo ? 0 : 1);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            ph = (k < 3) ? k : ((k < 3 + p3len) ? 3 : 4);
            Opcode   = (ph <= 1) ? op : 5'($urandom);
            Zflag    = (ph == 4) ? z : 1'($urandom);
            Cflag    = (ph == 4) ? c : 1'($urandom);
            if (ph == 3 && mem)
                MemReady = (!tmo && (k - 3) >= nwait);
            else
                MemReady = 1'($urandom);
            #1;
            check_status(name, exp_vec(ph, op, z, c));
            if (k == abort_at) begin
                #2 Reset = 1'b1;
                #1;
                exp_ret = 0;
                check_status({name, "_async"}, 19'b0);
                return;
            end
        end
        if (tmo) begin
            exp_halted = 1'b1;
            exp_buserr = 1'b1;
        end else begin
            exp_ret++;
            if (op == 5'h1F) exp_halted = 1'b1;
        end
    endtask

    task automatic park(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            Opcode = 5'($urandom);
            MemReady = 1'($urandom);
            Zflag = 1'($urandom);
            Cflag = 1'($urandom);
            #1;
            check_status(name, 19'b0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        Reset = 1'b1;
        #1;
        exp_ret = 0;
        exp_halted = 1'b0;
        exp_buserr = 1'b0;
        check_status("reset_held", 19'b0);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        check_status("reset_idle", 19'b0);
    endtask

    task automatic test_alu_stream();
        for (int i = 0; i < 3; i++) do_instr("alu_stream", 5'h01, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_load_wait();
        do_instr("load_wait", 5'h10, 3, 1'b0, 1'b0, -1);
        do_instr("load_nowait", 5'h10, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_jumps();
        do_instr("jz_taken", 5'h17, 0, 1'b1, 1'b0, -1);
        do_instr("jz_not", 5'h17, 0, 1'b0, 1'b1, -1);
        do_instr("jc_taken", 5'h18, 0, 1'b0, 1'b1, -1);
        do_instr("jc_not", 5'h18, 0, 1'b1, 1'b0, -1);
        do_instr("jmp", 5'h16, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            do_instr("random", 5'($urandom_range(0, 30)), $urandom_range(0, WMAX),
                     1'($urandom), 1'($urandom), -1);
    endtask

    task automatic test_wrap();
        test_reset();
        for (int i = 0; i < 17; i++) do_instr("wrap_nop", 5'h00, 0, 1'b0, 1'b0, -1);
        do_instr("wrap_after", 5'h00, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_timeout();
        do_instr("store_timeout", 5'h11, WMAX + 1, 1'b0, 1'b0, -1);
        park("timeout_park", 8);
    endtask

    task automatic test_halt();
        test_reset();
        do_instr("pre_halt", 5'h02, 0, 1'b0, 1'b0, -1);
        do_instr("halt", 5'h1F, 0, 1'b1, 1'b1, -1);
        park("halt_park", 10);
        test_reset();
        do_instr("after_halt", 5'h00, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_async_reset();
        do_instr("push_abort", 5'h12, 3, 1'b0, 1'b0, 4);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        check_status("abort_idle", 19'b0);
        do_instr("after_abort", 5'h13, 1, 1'b0, 1'b0, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_stream();
        test_load_wait();
        test_jumps();
        test_random();
        test_wrap();
        test_timeout();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
